// File: rtl/display_scan_controller_if.sv
// Value-side and display-side signals of the scan controller, bundled so the
// producer and the controller share one port list.
interface display_scan_controller_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  lz_blank;
  logic [3:0]            bcd_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_done;

  modport master (
    output enable, load, value, lz_blank,
    input  bcd_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, load, value, lz_blank,
    output bcd_out, digit_sel, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexes one BCD-to-7-segment decoder over DIGITS positions with a dark
// guard at the start of each slot, leading-zero blanking and frame-aligned updates.

// One link of the leading-zero chain: stays high only while this nibble and
// every more-significant nibble are zero.
module display_scan_lz_lane (
  input  logic [3:0] nib,
  input  logic       zero_hi,
  output logic       zero_out
);
  assign zero_out = zero_hi & (nib == 4'd0);
endmodule

module display_scan_controller #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  display_scan_controller_if.slave  bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_SHOW} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [DIGITS-1:0][3:0]  shadow;
  logic [DIGITS-1:0][3:0]  disp;
  logic [3:0]              bcd_q;
  logic [DIGITS-1:0]       sel_q;
  logic                    fd_q;

  logic [DIGITS:1]         zero_chain;
  logic [DIGITS-1:0]       show_ok;

  assign zero_chain[DIGITS] = 1'b1;
  assign show_ok[0]         = 1'b1;

  for (genvar i = 1; i < DIGITS; i++) begin : g_lane
    display_scan_lz_lane u_lane (
      .nib      (disp[i]),
      .zero_hi  (zero_chain[i+1]),
      .zero_out (zero_chain[i])
    );
    assign show_ok[i] = ~(bus.lz_blank & zero_chain[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      disp   <= '0;
      bcd_q  <= 4'hF;
      sel_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      bcd_q <= 4'hF;
      sel_q <= '0;
      fd_q  <= 1'b0;
      if (bus.load) shadow <= bus.value;
      if (!bus.enable) begin
        state <= S_IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt   <= '0;
            idx   <= '0;
            state <= S_GUARD;
          end
          S_GUARD: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(GUARD - 1)) state <= S_SHOW;
          end
          S_SHOW: begin
            if (show_ok[idx]) begin
              sel_q <= DIGITS'(1) << idx;
              bcd_q <= disp[idx];
            end
            if (cnt == CNT_W'(SCAN_DIV - 1)) begin
              cnt   <= '0;
              state <= S_GUARD;
              // Last lit cycle of the top digit: swap in the new frame here so
              // a frame never mixes old and new digits.
              if (idx == IDX_W'(DIGITS - 1)) begin
                idx  <= '0;
                disp <= shadow;
                fd_q <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = fd_q;
endmodule
